// File: rtl/l1_dcache_2way.sv
// Two-way set-associative write-back/write-allocate L1 cache: 16-bit word port, 128-bit line port.
// Optional hit/miss counters are enabled with `define L1_DCACHE_PERF_EN.
module l1_dcache_2way #(
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L1_DCACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, FILL} state_e;

  state_e             state_q, state_d;
  logic [1:0]         valid_q [SETS];
  logic [1:0]         dirty_q [SETS];
  logic [SETS-1:0]    lru_q;
  logic [TW-1:0]      tag_q   [SETS][2];
  logic [127:0]       data_q  [SETS][2];
  logic               victim_q;
  logic [15:0]        rdata_q;

  logic [IW-1:0]      idx;
  logic [TW-1:0]      tag;
  logic [2:0]         word;
  logic               req, hit0, hit1, hit, hit_way, victim;
  logic               unused_addr_lsb;

  assign idx  = mem_address[3+IW:4];
  assign tag  = mem_address[15:4+IW];
  assign word = mem_address[3:1];
  assign req  = mem_read | mem_write;
  assign unused_addr_lsb = mem_address[0];

  always_comb begin
    hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
    hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
    hit     = hit0 | hit1;
    hit_way = ~hit0;
    // Invalid ways are filled before anything valid is evicted, way 0 first.
    if (!valid_q[idx][0])      victim = 1'b0;
    else if (!valid_q[idx][1]) victim = 1'b1;
    else                       victim = lru_q[idx];
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit)                                          state_d = RESP;
          else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = WRITEBACK;
          else                                              state_d = FILL;
        end
      end
      RESP: begin
        mem_resp = 1'b1;
        state_d  = IDLE;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx][victim_q], idx, 4'b0000};
        pmem_wdata   = data_q[idx][victim_q];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rdata = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= '{default: '0};
      dirty_q  <= '{default: '0};
      lru_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        if (hit) begin
          if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
          else           rdata_q <= data_q[idx][hit_way][{word, 4'b0000} +: 16];
          lru_q[idx] <= ~hit_way;
        end else begin
          victim_q <= victim;
        end
      end
      if (state_q == FILL && pmem_resp) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line storage and tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req && hit && mem_write) begin
      if (mem_byte_enable[0]) data_q[idx][hit_way][{word, 4'b0000} +: 8] <= mem_wdata[7:0];
      if (mem_byte_enable[1]) data_q[idx][hit_way][{word, 4'b1000} +: 8] <= mem_wdata[15:8];
    end
    if (state_q == FILL && pmem_resp) begin
      data_q[idx][victim_q] <= pmem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

`ifdef L1_DCACHE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == IDLE && req) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache_2way.sv
// Directed table-driven bench for l1_dcache_2way with a latency-3 line memory responder.
module tb_l1_dcache_2way;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
`ifdef L1_DCACHE_PERF_EN
  logic [15:0]  hit_count, miss_count;
`endif

  l1_dcache_2way #(.SETS(8)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef L1_DCACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Backing store: untouched lines hold word i = line_address + i.
  logic [127:0] bmem [logic [15:0]];
  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    if (bmem.exists(a)) return bmem[a];
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = a + 16'(i);
    return l;
  endfunction

  int lat = 0, fill_cnt = 0, wb_cnt = 0, fill_cyc = 0, wb_cyc = 0, fill_start_cyc = 0;
  int excl_err = 0;
  logic [15:0]  last_fill_addr, last_wb_addr;
  logic [127:0] last_wb_data;

  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (pmem_read && pmem_write) excl_err++;
    if (reset || !(pmem_read || pmem_write)) lat = 0;
    else begin
      lat++;
      if (lat == 1 && pmem_read) fill_start_cyc = cyc;
      if (lat == 3) begin
        lat = 0;
        pmem_resp = 1'b1;
        if (pmem_write) begin
          bmem[pmem_address] = pmem_wdata;
          wb_cnt++; last_wb_addr = pmem_address; last_wb_data = pmem_wdata; wb_cyc = cyc;
        end else begin
          pmem_rdata = line_of(pmem_address);
          fill_cnt++; last_fill_addr = pmem_address; fill_cyc = cyc;
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_fill;
    logic [15:0] fill_addr;
    logic        exp_wb;
    logic [15:0] wb_addr;
    logic [15:0] wb_w2;
  } vec_t;

  task automatic access(input vec_t v, input string nm);
    int f0, w0, start, resp_cyc;
    logic got;
    logic [15:0] rd;
    got = 1'b0; rd = '0; resp_cyc = 0;
    @(negedge clk);
    f0 = fill_cnt; w0 = wb_cnt; start = cyc;
    mem_address = v.addr; mem_byte_enable = v.be; mem_wdata = v.wdata;
    mem_write = v.we; mem_read = ~v.we;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (mem_resp) begin got = 1'b1; rd = mem_rdata; resp_cyc = cyc; end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (!got) begin
      ncmp++; nerr++;
      $display("FAIL %s timeout: no mem_resp within 200 cycles", nm);
      return;
    end
    chk({nm, " fills"}, fill_cnt - f0, v.exp_fill ? 1 : 0);
    chk({nm, " writebacks"}, wb_cnt - w0, v.exp_wb ? 1 : 0);
    if (v.exp_fill) begin
      chk({nm, " fill_addr"}, last_fill_addr, v.fill_addr);
      chk({nm, " resp_after_fill"}, resp_cyc - fill_cyc, 2);
    end else begin
      chk({nm, " hit_latency"}, resp_cyc - start, 1);
    end
    if (v.exp_wb) begin
      chk({nm, " wb_addr"}, last_wb_addr, v.wb_addr);
      chk({nm, " wb_word2"}, last_wb_data[47:32], v.wb_w2);
      chk({nm, " fill_after_wb"}, fill_start_cyc - wb_cyc, 1);
    end
    if (!v.we) chk({nm, " rdata"}, rd, v.exp_rd);
  endtask

  vec_t vecs [21];
  logic [127:0] tmp;
  logic [4:0] pat;

  initial begin
    //            we    addr     be     wdata     rd        fill  faddr     wb    waddr     w2
    vecs[0]  = '{1'b0, 16'h1234, 2'b11, 16'h0000, 16'hBEEF, 1'b1, 16'h1230, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 16'h1234, 2'b01, 16'hAA55, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 16'h1234, 2'b11, 16'h0000, 16'hBE55, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 16'h1334, 2'b11, 16'h0000, 16'h1332, 1'b1, 16'h1330, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 16'h1434, 2'b11, 16'h0000, 16'h1432, 1'b1, 16'h1430, 1'b1, 16'h1230, 16'hBE55};
    vecs[5]  = '{1'b0, 16'h1234, 2'b11, 16'h0000, 16'hBE55, 1'b1, 16'h1230, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 16'h1334, 2'b11, 16'h0000, 16'h1332, 1'b1, 16'h1330, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 16'h1232, 2'b11, 16'h0000, 16'h1231, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 16'h1438, 2'b11, 16'h0000, 16'h1434, 1'b1, 16'h1430, 1'b0, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 16'h1230, 2'b11, 16'h0000, 16'h1230, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 16'h133E, 2'b11, 16'h0000, 16'h1337, 1'b1, 16'h1330, 1'b0, 16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 16'h1230, 2'b00, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{1'b0, 16'h1230, 2'b11, 16'h0000, 16'h1230, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[13] = '{1'b0, 16'h1530, 2'b11, 16'h0000, 16'h1530, 1'b1, 16'h1530, 1'b0, 16'h0000, 16'h0000};
    vecs[14] = '{1'b0, 16'h1630, 2'b11, 16'h0000, 16'h1630, 1'b1, 16'h1630, 1'b1, 16'h1230, 16'hBE55};
    vecs[15] = '{1'b1, 16'h1636, 2'b11, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[16] = '{1'b0, 16'h1636, 2'b11, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b1, 16'h1636, 2'b10, 16'hAB00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[18] = '{1'b0, 16'h1636, 2'b11, 16'h0000, 16'hAB34, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[19] = '{1'b0, 16'h0000, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[20] = '{1'b0, 16'h1534, 2'b11, 16'h0000, 16'h1532, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};

    tmp = line_of(16'h1230);
    tmp[47:32] = 16'hBEEF;
    bmem[16'h1230] = tmp;

    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset mem_resp", mem_resp, 0);
    chk("reset mem_rdata", mem_rdata, 0);
    chk("reset pmem_read", pmem_read, 0);
    chk("reset pmem_write", pmem_write, 0);
    chk("reset pmem_address", pmem_address, 0);
    chk("reset pmem_wdata", pmem_wdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      access(vecs[i], $sformatf("vec%0d", i));
`ifdef L1_DCACHE_PERF_EN
      if (i == 2) begin
        chk("perf miss_count", miss_count, 1);
        chk("perf hit_count", hit_count, 3);
      end
`endif
    end

    // Read held continuously: a new hit completes every other cycle.
    @(negedge clk);
    mem_address = 16'h1534; mem_read = 1'b1;
    pat = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pat[k] = mem_resp;
      if (mem_resp) chk($sformatf("b2b rdata %0d", k), mem_rdata, 16'h1532);
    end
    mem_read = 1'b0;
    chk("b2b resp pattern", pat, 5'b10101);

    // Reset while a fill is outstanding.
    @(negedge clk);
    mem_address = 16'h1234; mem_read = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (pmem_read) seen = 1'b1;
      end
      chk("midfill pmem_read seen", seen, 1);
    end
    #2 reset = 1'b1;
    #1;
    chk("midfill pmem_read drop", pmem_read, 0);
    chk("midfill pmem_address drop", pmem_address, 0);
    chk("midfill mem_resp", mem_resp, 0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    access('{1'b0, 16'h1234, 2'b11, 16'h0000, 16'hBE55, 1'b1, 16'h1230, 1'b0, 16'h0000, 16'h0000},
           "after_reset");

    chk("pmem read/write exclusive", excl_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
